pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Game-flow controller directly downstream of pong_graph. It consumes pong_graph's `hit`/`miss` strobes and player buttons. It produces `gra_still`, which freezes and re-centres the ball and paddles, plus the BCD score, remaining-ball count and a text-overlay state for the text/top-level mux. It owns the new-game, play, new-ball and game-over sequencing and a frame-based delay timer.

Parameters:
BALLS, 3, balls per game (1..3)
TIMER_FRAMES, 120, frame ticks of delay after a miss or game over (2 s at 60 Hz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
pix_x  in  10  current pixel column from vga_sync
pix_y  in  10  current pixel row from vga_sync
btn1  in  2  right-player buttons, level
btn2  in  2  left-player buttons, level
hit  in  1  pong_graph hit, level; may stay high many cycles
miss  in  1  pong_graph miss, level; may stay high many cycles
gra_still  out  1  1 = graphics frozen at initial positions
score_d1  out  4  score tens digit, BCD
score_d0  out  4  score units digit, BCD
ball_cnt  out  2  balls remaining
text_sel  out  2  overlay select: 0 = rules/start, 1 = playing, 2 = new ball, 3 = game over
game_over  out  1  high in OVER state

Behaviour:
- Frame tick: `tick = (pix_y==481) && (pix_x==0)`, one clk wide. It is the same instant pong_graph uses.
- Edge detection: `hit_q`/`miss_q` register the previous cycle's inputs.
  - `hit_ev = hit & ~hit_q`; `miss_ev = miss & ~miss_q`.
  - Only events count, never levels.
  - `hit_q`/`miss_q` reset to 0.
- Timer:
  - Width `$clog2(TIMER_FRAMES+1)`.
  - `timer_start` loads TIMER_FRAMES.
  - Otherwise decrements by 1 on `tick` while nonzero.
  - `timer_done = (timer==0)`.
- FSM states: NEWGAME, PLAY, NEWBALL, OVER.
  - NEWGAME:
    - `gra_still`=1, `text_sel`=0.
    - Stays while `(|btn1 | |btn2)==0`.
    - On any button high: next cycle PLAY, score cleared to 00, `ball_cnt` loaded with BALLS.
  - PLAY:
    - `gra_still`=0, `text_sel`=1.
    - `hit_ev`: score +1 BCD (d0 9→0 carries into d1); saturates at 99.
    - `miss_ev` with `ball_cnt`==1: `ball_cnt`→0, `timer_start`, go to OVER.
    - `miss_ev` with `ball_cnt`>1: `ball_cnt`−1, `timer_start`, go to NEWBALL.
    - `hit_ev` and `miss_ev` in the same cycle: miss processed, hit ignored.
  - NEWBALL:
    - `gra_still`=1, `text_sel`=2.
    - Go to PLAY when `timer_done` && any button high.
    - Buttons held during the delay are honoured the first cycle `timer_done` is true.
  - OVER:
    - `gra_still`=1, `text_sel`=3, `game_over`=1.
    - When `timer_done`: go to NEWGAME.
    - Score and `ball_cnt` hold (score stays visible in NEWGAME until the next start).
- Outside PLAY, `hit_ev`/`miss_ev` are ignored. Levels left over from the freeze are absorbed by the edge detectors.
- All outputs are registered or decoded from registered state; latency from event to output is 1 cycle.
- Reset values: state NEWGAME, `gra_still`=1, `score_d1`/`score_d0`=0, `ball_cnt`=BALLS, timer 0, `text_sel`=0, `game_over`=0.
- Reset mid-game returns to NEWGAME immediately (asynchronous).

Decomposition:
- Shared package `pong_pkg`:
  - FSM state enum (2 bits).
  - `text_sel` codes.
  - MAX_X=640, MAX_Y=480.
  - TICK_ROW=481 (also used by pong_graph).
- One sub-module `pong_bcd_counter`:
  - Two-digit BCD counter with `clr`, `inc` and saturation at 99.
  - Ports `clk`, `reset`, `clr`, `inc`, `d1`, `d0`.

Test Plan:
- Reset low then high, no buttons, 1000 cycles → state NEWGAME, `gra_still`=1, score 00, `ball_cnt`=3, `text_sel`=0.
- `btn1`=2'b01 one cycle in NEWGAME → next cycle `gra_still`=0, `text_sel`=1; `hit` high 800 cycles → score 01 (single increment).
- Ten separated `hit` pulses from score 09 → score 19; from 98, three pulses → 99 (saturated).
- `miss` pulse with `ball_cnt`=3 → `ball_cnt`=2, NEWBALL.
  - Button held throughout → PLAY exactly on the cycle after the 120th tick.
  - Button released before then → stays in NEWBALL.
- Third miss → `ball_cnt`=0, `game_over`=1, `text_sel`=3; after 120 ticks → NEWGAME with score retained.
- `hit` and `miss` rising in the same cycle → `ball_cnt` decremented, score unchanged.
- Reset asserted mid-PLAY (async, between clock edges) → outputs at reset values before the next edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: screen geometry, frame-tick row,
// game-flow state encoding and text-overlay select codes.
package pong_pkg;

  localparam int MAX_X    = 640;
  localparam int MAX_Y    = 480;
  localparam int TICK_ROW = 481;

  // The state encoding lines up with the overlay codes, so text_sel tracks state
  localparam logic [1:0] ST_NEWGAME = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
  localparam logic [1:0] ST_NEWBALL = 2'd2;
  localparam logic [1:0] ST_OVER    = 2'd3;

  typedef enum logic [1:0] {
    TXT_RULES   = 2'd0,
    TXT_PLAY    = 2'd1,
    TXT_NEWBALL = 2'd2,
    TXT_OVER    = 2'd3
  } text_sel_e;

  function automatic logic is_frame_tick(input logic [9:0] x, input logic [9:0] y);
    return (y == 10'(TICK_ROW)) && (x == 10'd0);
  endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD score counter with synchronous clear and increment that
// saturates at 99.
module pong_bcd_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  logic at_max;

  assign at_max = (d1 == 4'd9) && (d0 == 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1 <= 4'd0;
      d0 <= 4'd0;
    end else if (clr) begin
      d1 <= 4'd0;
      d0 <= 4'd0;
    end else if (inc && !at_max) begin
      if (d0 == 4'd9) begin
        d0 <= 4'd0;
        d1 <= d1 + 4'd1;
      end else begin
        d0 <= d0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences new game, play, new ball and game over,
// keeps the score and remaining balls, and freezes the graphics between rallies.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS        = 3,
  parameter int TIMER_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] ball_cnt,
  output logic [1:0] text_sel,
  output logic       game_over
);

  localparam int TW = $clog2(TIMER_FRAMES + 1);

  logic [1:0]    state, state_next;
  logic          hit_q, miss_q;
  logic          hit_ev, miss_ev;
  logic          tick, any_btn;
  logic [TW-1:0] timer;
  logic          timer_start, timer_done;
  logic          score_clr, score_inc;
  logic          ball_load, ball_dec;

  assign tick       = is_frame_tick(pix_x, pix_y);
  assign any_btn    = (|btn1) || (|btn2);
  assign hit_ev     = hit & ~hit_q;
  assign miss_ev    = miss & ~miss_q;
  assign timer_done = (timer == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      hit_q  <= hit;
      miss_q <= miss;
    end
  end

  always_comb begin
    state_next  = state;
    timer_start = 1'b0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    ball_load   = 1'b0;
    ball_dec    = 1'b0;
    case (state)
      ST_NEWGAME: begin
        if (any_btn) begin
          state_next = ST_PLAY;
          score_clr  = 1'b1;
          ball_load  = 1'b1;
        end
      end
      ST_PLAY: begin
        // A miss wins over a simultaneous hit
        if (miss_ev) begin
          ball_dec    = 1'b1;
          timer_start = 1'b1;
          state_next  = (ball_cnt == 2'd1) ? ST_OVER : ST_NEWBALL;
        end else if (hit_ev) begin
          score_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (timer_done && any_btn) state_next = ST_PLAY;
      end
      default: begin
        if (timer_done) state_next = ST_NEWGAME;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_NEWGAME;
      ball_cnt <= 2'(BALLS);
    end else begin
      state <= state_next;
      if (ball_load)     ball_cnt <= 2'(BALLS);
      else if (ball_dec) ball_cnt <= ball_cnt - 2'd1;
    end
  end

  // Frame-paced delay: counts down once per frame until it reaches zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   timer <= '0;
    else if (timer_start)         timer <= TW'(TIMER_FRAMES);
    else if (tick && !timer_done) timer <= timer - TW'(1);
  end

  pong_bcd_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .d1    (score_d1),
    .d0    (score_d0)
  );

  always_comb begin
    case (state)
      ST_PLAY:    text_sel = TXT_PLAY;
      ST_NEWBALL: text_sel = TXT_NEWBALL;
      ST_OVER:    text_sel = TXT_OVER;
      default:    text_sel = TXT_RULES;
    endcase
  end

  assign gra_still = (state != ST_PLAY);
  assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: vector table, hand sequences for the timed
// corners and a randomized run against an integer-level game model.
module tb_pong_game_ctrl;

  localparam int BALLS = 3;
  localparam int TF    = 120;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x, pix_y;
  logic [1:0] btn1, btn2;
  logic       hit, miss;
  logic       gra_still, game_over;
  logic [3:0] score_d1, score_d0;
  logic [1:0] ball_cnt, text_sel;

  int checks = 0;
  int errors = 0;

  // Game model: mode 0 rules, 1 playing, 2 new ball, 3 over; score as an integer
  int m_mode, m_score, m_balls, m_timer;
  bit m_hq, m_mq;

  typedef struct {
    logic [1:0] b1, b2;
    logic       h, m;
    logic [1:0] txt;
    logic [7:0] score;
    logic [1:0] ball;
  } vec_t;

  vec_t tbl[10];

  pong_game_ctrl #(.BALLS(BALLS), .TIMER_FRAMES(TF)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .btn1      (btn1),
    .btn2      (btn2),
    .hit       (hit),
    .miss      (miss),
    .gra_still (gra_still),
    .score_d1  (score_d1),
    .score_d0  (score_d0),
    .ball_cnt  (ball_cnt),
    .text_sel  (text_sel),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_score = 0; m_balls = BALLS; m_timer = 0; m_hq = 0; m_mq = 0;
  endtask

  function automatic int dut_vec();
    return int'({gra_still, score_d1, score_d0, ball_cnt, text_sel, game_over});
  endfunction

  function automatic int model_vec();
    logic [13:0] v;
    v = {(m_mode != 1), 4'(m_score / 10), 4'(m_score % 10), 2'(m_balls), 2'(m_mode), (m_mode == 3)};
    return int'(v);
  endfunction

  function automatic int score_bcd();
    return int'({score_d1, score_d0});
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic apply_stimulus(input logic [1:0] b1, input logic [1:0] b2,
                                input logic h, input logic m, input bit tk);
    bit hev, mev, btn, start;
    btn1 = b1; btn2 = b2; hit = h; miss = m;
    if (tk) begin
      pix_x = 10'd0; pix_y = 10'd481;
    end else begin
      pix_x = 10'($urandom_range(1, 799));
      pix_y = 10'($urandom_range(0, 524));
    end
    hev = h && !m_hq; mev = m && !m_mq; btn = (b1 != 0) || (b2 != 0); start = 0;
    case (m_mode)
      0: if (btn) begin m_mode = 1; m_score = 0; m_balls = BALLS; end
      1: if (mev) begin
           m_balls = m_balls - 1; start = 1;
           m_mode  = (m_balls == 0) ? 3 : 2;
         end else if (hev && m_score < 99) m_score = m_score + 1;
      2: if (m_timer == 0 && btn) m_mode = 1;
      default: if (m_timer == 0) m_mode = 0;
    endcase
    if (start) m_timer = TF;
    else if (tk && m_timer > 0) m_timer = m_timer - 1;
    m_hq = h; m_mq = m;
    @(posedge clk); #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hit_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic frame_ticks(input int n, input logic [1:0] b);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(b, 2'b00, 1'b0, 1'b0, 1'b1);
      apply_stimulus(b, 2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    tbl[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 2'd3};
    tbl[1] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 8'h00, 2'd3};
    tbl[2] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'd1, 8'h01, 2'd3};
    tbl[3] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'd1, 8'h01, 2'd3};
    tbl[4] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'd1, 8'h01, 2'd3};
    tbl[5] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'd1, 8'h02, 2'd3};
    tbl[6] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'd1, 8'h02, 2'd3};
    tbl[7] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'd2, 8'h02, 2'd2};
    tbl[8] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'd2, 8'h02, 2'd2};
    tbl[9] = '{2'b00, 2'b10, 1'b0, 1'b0, 2'd2, 8'h02, 2'd2};

    reset = 1'b0; btn1 = 0; btn2 = 0; hit = 0; miss = 0; pix_x = 0; pix_y = 0;
    model_reset();
    #12;
    check("reset_values", dut_vec(), model_vec());
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++)
      apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
    check("idle_text", int'(text_sel), 0);
    check("idle_still", int'(gra_still), 1);
    check("idle_balls", int'(ball_cnt), 3);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tbl[i].b1, tbl[i].b2, tbl[i].h, tbl[i].m, 1'b0);
      check($sformatf("tbl%0d_text", i), int'(text_sel), int'(tbl[i].txt));
      check($sformatf("tbl%0d_score", i), score_bcd(), int'(tbl[i].score));
      check($sformatf("tbl%0d_balls", i), int'(ball_cnt), int'(tbl[i].ball));
    end

    // Button held through the new-ball delay: resume right after the last tick
    frame_ticks(TF - 1, 2'b01);
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    check("held_last_tick", int'(text_sel), 2);
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("held_resume", int'(text_sel), 1);
    check("held_still", int'(gra_still), 0);

    for (int i = 0; i < 800; i++) apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    check("hit_level", score_bcd(), 'h03);
    idle(1);
    hit_pulse(6);
    check("score_09", score_bcd(), 'h09);
    hit_pulse(10);
    check("score_19", score_bcd(), 'h19);
    hit_pulse(79);
    check("score_98", score_bcd(), 'h98);
    hit_pulse(3);
    check("score_sat", score_bcd(), 'h99);

    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    check("miss2_balls", int'(ball_cnt), 1);
    check("miss2_text", int'(text_sel), 2);
    idle(1);
    frame_ticks(TF + 5, 2'b00);
    check("released_wait", int'(text_sel), 2);
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("released_resume", int'(text_sel), 1);

    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    check("over_balls", int'(ball_cnt), 0);
    check("over_flag", int'(game_over), 1);
    check("over_text", int'(text_sel), 3);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(1);
    frame_ticks(TF - 1, 2'b00);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("over_last_tick", int'(game_over), 1);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("newgame_text", int'(text_sel), 0);
    check("newgame_score_kept", score_bcd(), 'h99);

    apply_stimulus(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    check("restart_score", score_bcd(), 'h00);
    check("restart_balls", int'(ball_cnt), 3);
    hit_pulse(1);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check("both_balls", int'(ball_cnt), 2);
    check("both_score", score_bcd(), 'h01);

    for (int i = 0; i < 4000; i++)
      apply_stimulus(($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00,
                     ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00,
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 3) == 0));

    // Asynchronous reset between edges while playing
    @(negedge clk); reset = 1'b0; #2; reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    hit_pulse(2);
    check("pre_reset_text", int'(text_sel), 1);
    @(negedge clk); reset = 1'b0; #1;
    model_reset();
    check("async_reset", dut_vec(), model_vec());
    check("async_reset_text", int'(text_sel), 0);
    #2; reset = 1'b1;
    @(posedge clk); #1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
